// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory read port plus decode valid/ready port.
interface fetch_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_gnt;
  logic             mem_rvalid;
  logic [WIDTH-1:0] mem_rdata;
  logic             inst_valid;
  logic [WIDTH-1:0] inst_data;
  logic [WIDTH-1:0] inst_pc;
  logic             inst_ready;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the PC register, issues single outstanding
// reads, buffers one instruction for decode and flushes wrong-path data on redirect.
module fetch_ctrl #(
  parameter int unsigned           WIDTH = 16,
  parameter logic [WIDTH-1:0]      INIT  = '0,
  parameter int unsigned           INC   = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] pc_q,
  output logic             pc_en,
  output logic [WIDTH-1:0] pc_d,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  fetch_ctrl_if.master     bus
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] inst_data_q, inst_pc_q;
  logic             load_c;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_REQ;
    else         state_q <= state_d;
  end

  // Next-state logic; redirect overrides every other event
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (bus.mem_gnt) state_d = redirect ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (redirect)            state_d = bus.mem_rvalid ? S_REQ : S_DRAIN;
        else if (bus.mem_rvalid) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (redirect || bus.inst_ready) state_d = S_REQ;
      end
      S_DRAIN: begin
        if (bus.mem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // Output decode; PC write priority is reset > redirect > increment
  always_comb begin
    pc_en       = 1'b0;
    pc_d        = pc_q + WIDTH'(INC);
    load_c      = 1'b0;
    bus.mem_req = (state_q == S_REQ) && resetn;
    bus.inst_valid = (state_q == S_HOLD);
    if (!resetn) begin
      pc_en = 1'b1;
      pc_d  = INIT;
    end else if (redirect) begin
      pc_en = 1'b1;
      pc_d  = redirect_pc;
    end else if (state_q == S_WAIT && bus.mem_rvalid) begin
      pc_en  = 1'b1;
      load_c = 1'b1;
    end
  end

  // Instruction buffer, captured only on a non-flushed response
  always_ff @(posedge clk) begin
    if (!resetn) begin
      inst_data_q <= '0;
      inst_pc_q   <= '0;
    end else if (load_c) begin
      inst_data_q <= bus.mem_rdata;
      inst_pc_q   <= pc_q;
    end
  end

  assign bus.mem_addr  = pc_q;
  assign bus.inst_data = inst_data_q;
  assign bus.inst_pc   = inst_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: cycle table with hand-computed expectations
// plus a zero-wait throughput sequence.
module tb_fetch_ctrl;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         resetn;
  logic [W-1:0] pc_q;
  logic         pc_en;
  logic [W-1:0] pc_d;
  logic         redirect;
  logic [W-1:0] redirect_pc;

  fetch_ctrl_if #(.WIDTH(W)) bus ();

  fetch_ctrl #(.WIDTH(W), .INIT(16'h0000), .INC(1)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .pc_q        (pc_q),
    .pc_en       (pc_en),
    .pc_d        (pc_d),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // PC register owned by the core
  always_ff @(posedge clk) begin
    if (pc_en) pc_q <= pc_d;
  end

  typedef struct {
    logic         rst_n;
    logic         rd;
    logic [W-1:0] rpc;
    logic         gnt;
    logic         rv;
    logic [W-1:0] rdata;
    logic         rdy;
    logic         full;
    logic         e_req;
    logic [W-1:0] e_addr;
    logic         e_val;
    logic [W-1:0] e_data;
    logic [W-1:0] e_pc;
    logic         e_en;
    logic [W-1:0] e_pcd;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic vec_t mk(logic rst_n, logic rd, logic [W-1:0] rpc, logic gnt, logic rv,
                              logic [W-1:0] rdata, logic rdy, logic full, logic e_req,
                              logic [W-1:0] e_addr, logic e_val, logic [W-1:0] e_data,
                              logic [W-1:0] e_pc, logic e_en, logic [W-1:0] e_pcd);
    vec_t v;
    v.rst_n = rst_n; v.rd = rd; v.rpc = rpc; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.rdy = rdy; v.full = full; v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val;
    v.e_data = e_data; v.e_pc = e_pc; v.e_en = e_en; v.e_pcd = e_pcd;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    else             n_pass++;
  endtask

  task automatic drive(input vec_t v);
    resetn         = v.rst_n;
    redirect       = v.rd;
    redirect_pc    = v.rpc;
    bus.mem_gnt    = v.gnt;
    bus.mem_rvalid = v.rv;
    bus.mem_rdata  = v.rdata;
    bus.inst_ready = v.rdy;
  endtask

  initial begin
    vec_t v;
    //                rst rd rpc       gnt rv rdata     rdy full req addr      val data      pc        en pcd
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0000, 1, 1,   1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h1234, 0, 1,   0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0001));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 16'h0001, 1, 16'h1234, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 1,   0, 16'h0001, 1, 16'h1234, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1,   1, 16'h0001, 0, 16'h1234, 16'h0000, 0, 16'h0000));
    // redirect in WAIT, stale response three cycles later
    vecs.push_back(mk(1, 1, 16'h0040, 0, 0, 16'h0000, 0, 1,   0, 16'h0001, 0, 16'h1234, 16'h0000, 1, 16'h0040));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,   0, 16'h0040, 0, 16'h1234, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,   0, 16'h0040, 0, 16'h1234, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'hDEAD, 1, 1,   0, 16'h0040, 0, 16'h1234, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1,   1, 16'h0040, 0, 16'h1234, 16'h0000, 0, 16'h0000));
    // redirect coincident with the response
    vecs.push_back(mk(1, 1, 16'h0100, 0, 1, 16'hBEEF, 0, 1,   0, 16'h0040, 0, 16'h1234, 16'h0000, 1, 16'h0100));
    vecs.push_back(mk(1, 1, 16'hFFFF, 0, 0, 16'h0000, 0, 1,   1, 16'h0100, 0, 16'h1234, 16'h0000, 1, 16'hFFFF));
    // fetch at 0xFFFF and wrap
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1,   1, 16'hFFFF, 0, 16'h1234, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'hA5A5, 0, 1,   0, 16'hFFFF, 0, 16'h1234, 16'h0000, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 1,   0, 16'h0000, 1, 16'hA5A5, 16'hFFFF, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1,   1, 16'h0000, 0, 16'hA5A5, 16'hFFFF, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 16'hA5A5, 16'hFFFF, 0, 16'h0000));
    // reset during DRAIN, then a stray response in REQ
    vecs.push_back(mk(1, 1, 16'h0300, 0, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 16'hA5A5, 16'hFFFF, 1, 16'h0300));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,   0, 16'h0300, 0, 16'hA5A5, 16'hFFFF, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h7777, 0, 1,   1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1,   1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h4242, 0, 1,   0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0001));
    // redirect in HOLD with inst_ready high
    vecs.push_back(mk(1, 1, 16'h0050, 0, 0, 16'h0000, 1, 1,   0, 16'h0001, 1, 16'h4242, 16'h0000, 1, 16'h0050));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,   1, 16'h0050, 0, 16'h4242, 16'h0000, 0, 16'h0000));

    for (int r = 0; r < vecs.size(); r++) begin
      v = vecs[r];
      @(negedge clk);
      drive(v);
      #1;
      chk("mem_req", r, W'(bus.mem_req), W'(v.e_req));
      chk("pc_en",   r, W'(pc_en),       W'(v.e_en));
      if (v.e_en) chk("pc_d", r, pc_d, v.e_pcd);
      if (v.full) begin
        chk("mem_addr",   r, bus.mem_addr,        v.e_addr);
        chk("inst_valid", r, W'(bus.inst_valid),  W'(v.e_val));
        chk("inst_data",  r, bus.inst_data,       v.e_data);
        chk("inst_pc",    r, bus.inst_pc,         v.e_pc);
      end
    end

    // Zero-wait streaming: one instruction every three cycles from 0x0050
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      resetn = 1'b1; redirect = 1'b0; bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b0; bus.inst_ready = 1'b0;
      #1;
      chk("s_req",  100 + i, W'(bus.mem_req), W'(1'b1));
      chk("s_addr", 100 + i, bus.mem_addr,    W'(16'h0050 + i));
      @(negedge clk);
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = W'(16'hC000 + i);
      #1;
      chk("s_pc_en", 100 + i, W'(pc_en), W'(1'b1));
      chk("s_pc_d",  100 + i, pc_d,      W'(16'h0051 + i));
      @(negedge clk);
      bus.mem_rvalid = 1'b0; bus.inst_ready = 1'b1;
      #1;
      chk("s_valid", 100 + i, W'(bus.inst_valid), W'(1'b1));
      chk("s_data",  100 + i, bus.inst_data,      W'(16'hC000 + i));
      chk("s_pc",    100 + i, bus.inst_pc,        W'(16'h0050 + i));
    end
    @(negedge clk);
    bus.inst_ready = 1'b0; bus.mem_gnt = 1'b0;
    #1;
    chk("s_req_end",  200, W'(bus.mem_req), W'(1'b1));
    chk("s_addr_end", 200, bus.mem_addr,    16'h0053);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
